mdu_iter: RTL

- Multi-cycle responder for the EX-stage handshake: executes RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) iteratively.
- The main controller FSM pulses start, then waits in EX until valid.
- Radix-2 shift-add multiply and restoring division share one XLEN-bit datapath and iteration counter.

---
 rtl/mdu_iter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit for the EX-stage handshake.
//
// A radix-2 shift-add multiplier and a restoring divider share one pair of
// XLEN-bit working registers (hi/lo) and one iteration counter. Operands are
// reduced to magnitudes when an op is accepted. The sign is applied once, when
// the final iteration loads the result register.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (discards any in-flight op)
//   start  in   request, sampled only while busy=0
//   func3  in   M-ext op: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   rs1    in   operand A (dividend)
//   rs2    in   operand B (divisor)
//   result out  registered result, held until the next op completes
//   busy   out  high while iterating (CALC)
//   valid  out  single-cycle completion pulse (DONE)
//
// Optional build macro MDU_EARLY_OUT_EN: when it is defined, divide-by-zero
// and signed-overflow divisions skip CALC and complete in DONE immediately
// after acceptance. The results are the same as in the default build.
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            valid
);
    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     counter_reg;
    logic [2:0]        op_reg;
    logic [XLEN-1:0]   rs1_reg, b_mag_reg, hi_reg, lo_reg, result_reg;
    logic              neg_reg, div0_reg, ovf_reg;

    // Operand decode for the request on the inputs.
    logic              a_signed, b_signed, a_neg, b_neg, neg_in;
    logic              div0_in, ovf_in, early_out, accept, last_iter;
    logic [XLEN-1:0]   a_mag, b_mag;

    // Datapath for one iteration, plus the final result.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   hi_next, lo_next, res_final;
    logic [2*XLEN-1:0] prod, prod_s;

    // Result of the two special division cases. This is shared by the
    // early-out path and by the fix-up done when CALC finishes.
    function automatic logic [XLEN-1:0] special_result(
        input logic            is_rem,
        input logic            div0,
        input logic [XLEN-1:0] dividend
    );
        if (div0)
            return is_rem ? dividend : {XLEN{1'b1}};
        else
            return is_rem ? {XLEN{1'b0}} : dividend;
    endfunction

    always_comb begin
        a_signed = func3[2] ? ~func3[0] : (func3[1:0] != 2'b11);
        b_signed = func3[2] ? ~func3[0] : ~func3[1];
        a_neg    = a_signed & rs1[XLEN-1];
        b_neg    = b_signed & rs2[XLEN-1];
        a_mag    = a_neg ? -rs1 : rs1;
        b_mag    = b_neg ? -rs2 : rs2;
        // A remainder follows the dividend's sign. Every other op uses the
        // product/quotient sign.
        neg_in   = (func3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
        div0_in  = func3[2] && (rs2 == '0);
        ovf_in   = func3[2] && !func3[0] && !div0_in &&
                   (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == {XLEN{1'b1}});
`ifdef MDU_EARLY_OUT_EN
        early_out = div0_in || ovf_in;
`else
        early_out = 1'b0;
`endif
        accept    = start && (state_reg != S_CALC);
        last_iter = (counter_reg == CW'(XLEN - 1));
    end

    // One iteration step.
    // Multiply: hi accumulates the product and lo shifts the multiplier out.
    // Divide: hi holds the partial remainder. lo shifts the dividend out and
    // the quotient bits in.
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_mag_reg} : '0);
        div_shift = {hi_reg, lo_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_mag_reg};
        hi_next   = hi_reg;
        lo_next   = lo_reg;
        if (!op_reg[2]) begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            hi_next = div_diff[XLEN-1:0];
            lo_next = {lo_reg[XLEN-2:0], 1'b1};
        end else begin
            hi_next = div_shift[XLEN-1:0];
            lo_next = {lo_reg[XLEN-2:0], 1'b0};
        end
    end

    // Sign fix-up and half selection, applied to the last iteration's output.
    always_comb begin
        prod      = {hi_next, lo_next};
        prod_s    = neg_reg ? -prod : prod;
        res_final = '0;
        if (!op_reg[2])
            res_final = (op_reg[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        else if (div0_reg || ovf_reg)
            res_final = special_result(op_reg[1], div0_reg, rs1_reg);
        else if (op_reg[1])
            res_final = neg_reg ? -hi_next : hi_next;
        else
            res_final = neg_reg ? -lo_next : lo_next;
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            counter_reg <= '0;
            result_reg  <= '0;
            op_reg      <= '0;
            rs1_reg     <= '0;
            b_mag_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            neg_reg     <= 1'b0;
            div0_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg      <= func3;
                rs1_reg     <= rs1;
                b_mag_reg   <= b_mag;
                hi_reg      <= '0;
                lo_reg      <= a_mag;
                neg_reg     <= neg_in;
                div0_reg    <= div0_in;
                ovf_reg     <= ovf_in;
                counter_reg <= '0;
                if (early_out)
                    result_reg <= special_result(func3[1], div0_in, rs1);
            end else if (state_reg == S_CALC) begin
                hi_reg      <= hi_next;
                lo_reg      <= lo_next;
                counter_reg <= counter_reg + CW'(1);
                if (last_iter)
                    result_reg <= res_final;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_CALC:  if (last_iter) state_next = S_DONE;
            default: begin
                if (accept)
                    state_next = early_out ? S_DONE : S_CALC;
                else
                    state_next = S_IDLE;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        busy   = (state_reg == S_CALC);
        valid  = (state_reg == S_DONE);
        result = result_reg;
    end
endmodule
